row_sched_ctrl: RTL and testbench

//  Sequencer for mem_controller. Issues its start pulse and latches its mode.

---
 rtl/row_sched_pkg.sv | 30 +++
 rtl/row_sched_ctrl_row_pass_counter.sv | 49 ++++
 rtl/row_sched_ctrl.sv | 135 +++++++++++++
 tb/tb_row_sched_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_sched_pkg.sv
// Shared constants, state encoding and width helper for the row scheduler.
package row_sched_pkg;

    // Ceiling log2 used to size index counters from their maximum count.
    function automatic int c_log_2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int IF_WIDTH        = 16;
    localparam int ACT_INDEX_WIDTH = c_log_2(IF_WIDTH);
    localparam int SER_PASSES      = 5;
    localparam int ROW_CNT_WIDTH   = 8;
    localparam int PASS_IDX_WIDTH  = c_log_2(SER_PASSES);

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/row_sched_ctrl_row_pass_counter.sv
// Per-row cycle counter: holds the pass length, the in-pass cycle index and
// the pass index, and flags the last cycle of a pass and the final pass of a row.
module row_pass_counter
    import row_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       run,
    input  logic                       mode_ser,
    input  logic [ACT_INDEX_WIDTH-1:0] row_val_num,
    output logic [ACT_INDEX_WIDTH-1:0] cnt,
    output logic                       last_cycle,
    output logic                       last_pass
);

    localparam logic [PASS_IDX_WIDTH-1:0] LAST_PASS_IDX = PASS_IDX_WIDTH'(SER_PASSES - 1);

    logic [ACT_INDEX_WIDTH-1:0] len;
    logic [PASS_IDX_WIDTH-1:0]  pass_idx;
    logic                       zero_row;

    // An empty row still takes one cycle, so its length is forced to 1.
    assign last_cycle = (cnt == (len - ACT_INDEX_WIDTH'(1)));
    assign last_pass  = (mode_ser == MODE_PAR) || zero_row || (pass_idx == LAST_PASS_IDX);

    // Latch the row length on load; step cnt, wrapping into the next pass or back to 0 at row end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len      <= '0;
            zero_row <= 1'b0;
            cnt      <= '0;
            pass_idx <= '0;
        end else if (load) begin
            len      <= (row_val_num == '0) ? ACT_INDEX_WIDTH'(1) : row_val_num;
            zero_row <= (row_val_num == '0);
            cnt      <= '0;
            pass_idx <= '0;
        end else if (run) begin
            if (last_cycle) begin
                cnt      <= '0;
                pass_idx <= last_pass ? '0 : pass_idx + PASS_IDX_WIDTH'(1);
            end else begin
                cnt <= cnt + ACT_INDEX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/row_sched_ctrl.sv
// Layer sequencer for mem_controller: issues the start pulse, holds the mode,
// walks the rows and generates the per-pass and per-row completion pulses.
module row_sched_ctrl
    import row_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_start,
    input  logic                       cfg_mode,
    input  logic [ROW_CNT_WIDTH-1:0]   cfg_rows,
    input  logic                       en,
    input  logic [ACT_INDEX_WIDTH-1:0] row_val_num,
    output logic                       start,
    output logic                       mode,
    output logic [ACT_INDEX_WIDTH-1:0] cnt,
    output logic                       row_finish_done_0,
    output logic                       row_cal_done,
    output logic                       row_finish_done_1,
    output logic                       busy,
    output logic                       done
);

    state_t                     state_q;
    state_t                     state_d;
    logic                       mode_q;
    logic                       start_q;
    logic [ROW_CNT_WIDTH-1:0]   rows_q;
    logic [ROW_CNT_WIDTH-1:0]   row_idx_q;
    logic                       accept;
    logic                       load;
    logic                       run;
    logic                       last_cycle;
    logic                       last_pass;
    logic                       row_end;
    logic                       last_row;

    assign accept   = (state_q == S_IDLE) && cfg_start && (cfg_rows != '0);
    assign load     = (state_q == S_LOAD) && en;
    assign run      = (state_q == S_RUN);
    assign row_end  = run && last_cycle && last_pass;
    assign last_row = (row_idx_q == (rows_q - ROW_CNT_WIDTH'(1)));

    row_pass_counter u_row_pass_counter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .run         (run),
        .mode_ser    (mode_q),
        .row_val_num (row_val_num),
        .cnt         (cnt),
        .last_cycle  (last_cycle),
        .last_pass   (last_pass)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a zero-row request skips straight to DONE without a start pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_rows != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (row_end) begin
                    state_d = last_row ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Layer configuration, row index and the registered start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_PAR;
            rows_q    <= '0;
            row_idx_q <= '0;
            start_q   <= 1'b0;
        end else begin
            start_q <= accept;
            if (accept) begin
                mode_q    <= cfg_mode;
                rows_q    <= cfg_rows;
                row_idx_q <= '0;
            end else if (row_end && !last_row) begin
                row_idx_q <= row_idx_q + ROW_CNT_WIDTH'(1);
            end
        end
    end

    // Moore output decode from registered state and counter.
    always_comb begin
        busy              = 1'b0;
        done              = 1'b0;
        row_finish_done_0 = 1'b0;
        row_cal_done      = 1'b0;
        case (state_q)
            S_LOAD: busy = 1'b1;
            S_RUN: begin
                busy              = 1'b1;
                row_finish_done_0 = last_cycle;
                row_cal_done      = last_cycle && last_pass;
            end
            S_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign start             = start_q;
    assign mode              = mode_q;
    assign row_finish_done_1 = 1'b0;

endmodule

// File: tb/tb_row_sched_ctrl.sv
// Directed bench for row_sched_ctrl: layer runs in both modes, empty rows,
// LOAD stalls, ignored requests and mid-layer reset.
module tb_row_sched_ctrl;
    import row_sched_pkg::*;

    logic                       clk;
    logic                       reset;
    logic                       cfg_start;
    logic                       cfg_mode;
    logic [ROW_CNT_WIDTH-1:0]   cfg_rows;
    logic                       en;
    logic [ACT_INDEX_WIDTH-1:0] row_val_num;
    logic                       start;
    logic                       mode;
    logic [ACT_INDEX_WIDTH-1:0] cnt;
    logic                       row_finish_done_0;
    logic                       row_cal_done;
    logic                       row_finish_done_1;
    logic                       busy;
    logic                       done;

    int checks;
    int errors;

    row_sched_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_mode          (cfg_mode),
        .cfg_rows          (cfg_rows),
        .en                (en),
        .row_val_num       (row_val_num),
        .start             (start),
        .mode              (mode),
        .cnt               (cnt),
        .row_finish_done_0 (row_finish_done_0),
        .row_cal_done      (row_cal_done),
        .row_finish_done_1 (row_finish_done_1),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until row_cal_done is seen; n = cycles taken (-1 on timeout), fins = finish pulses seen.
    task automatic wait_cal(input int limit, output int n, output int fins);
        bit found;
        found = 0;
        n     = 0;
        fins  = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            n++;
            if (row_finish_done_0) fins++;
            if (row_cal_done) begin
                found = 1;
                break;
            end
        end
        if (!found) n = -1;
    endtask

    task automatic request(input logic m, input logic [ROW_CNT_WIDTH-1:0] rows);
        cfg_start = 1'b1;
        cfg_mode  = m;
        cfg_rows  = rows;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        reset = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_rows = '0;
        en = 1'b0; row_val_num = '0;
        #3;
        outs = {start, mode, row_finish_done_0, row_cal_done, row_finish_done_1, busy, done, 1'b0};
        checks++;
        if (outs !== 8'h00) begin errors++; $display("FAIL reset_outs: got %b expected 00000000", outs); end
        checks++;
        if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || start !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b done=%b start=%b expected 0 0 0", busy, done, start);
        end
    endtask

    task automatic test_mode0_rows();
        int n, f;
        en = 1'b1; row_val_num = 4'd10;
        request(1'b0, 8'd3);
        checks++;
        if (start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL m0_start: start=%b busy=%b expected 1 1", start, busy); end
        wait_cal(40, n, f);
        checks++;
        if (n !== 10 || f !== 1) begin errors++; $display("FAIL m0_row0: cycles=%0d fins=%0d expected 10 1", n, f); end
        checks++;
        if (cnt !== 4'd9 || row_finish_done_0 !== 1'b1) begin errors++; $display("FAIL m0_row0_cnt: cnt=%0d fin=%b expected 9 1", cnt, row_finish_done_0); end
        row_val_num = 4'd13;
        wait_cal(40, n, f);
        checks++;
        if (n !== 14 || f !== 1) begin errors++; $display("FAIL m0_row1: cycles=%0d fins=%0d expected 14 1", n, f); end
        row_val_num = 4'd8;
        wait_cal(40, n, f);
        checks++;
        if (n !== 9 || f !== 1) begin errors++; $display("FAIL m0_row2: cycles=%0d fins=%0d expected 9 1", n, f); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL m0_done: done=%b busy=%b expected 1 0", done, busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL m0_done_width: done=%b expected 0", done); end
    endtask

    task automatic test_mode1_passes();
        en = 1'b1; row_val_num = 4'd3;
        request(1'b1, 8'd1);
        checks++;
        if (mode !== 1'b1 || start !== 1'b1) begin errors++; $display("FAIL m1_start: mode=%b start=%b expected 1 1", mode, start); end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (cnt !== 4'(i % 3) || row_finish_done_0 !== ((i % 3) == 2) || row_cal_done !== (i == 14) || start !== 1'b0) begin
                errors++;
                $display("FAIL m1_cycle%0d: cnt=%0d fin=%b cal=%b start=%b expected %0d %b %b 0",
                         i, cnt, row_finish_done_0, row_cal_done, start, i % 3, (i % 3) == 2, i == 14);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || row_cal_done !== 1'b0) begin errors++; $display("FAIL m1_done: done=%b cal=%b expected 1 0", done, row_cal_done); end
        tick();
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL m1_mode_hold: mode=%b expected 1", mode); end
    endtask

    task automatic test_zero_row();
        int n, f;
        en = 1'b1; row_val_num = 4'd0;
        request(1'b0, 8'd2);
        tick();
        checks++;
        if (row_finish_done_0 !== 1'b1 || row_cal_done !== 1'b1 || cnt !== 4'd0) begin
            errors++; $display("FAIL zero_row: fin=%b cal=%b cnt=%0d expected 1 1 0", row_finish_done_0, row_cal_done, cnt);
        end
        row_val_num = 4'd7;
        wait_cal(40, n, f);
        checks++;
        if (n !== 8 || f !== 1) begin errors++; $display("FAIL zero_next_row: cycles=%0d fins=%0d expected 8 1", n, f); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b expected 1", done); end
        tick();
    endtask

    task automatic test_load_stall();
        int n, f;
        en = 1'b0; row_val_num = 4'd4;
        request(1'b0, 8'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (cnt !== 4'd0 || row_finish_done_0 !== 1'b0 || row_cal_done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall%0d: cnt=%0d fin=%b cal=%b busy=%b expected 0 0 0 1",
                                   i, cnt, row_finish_done_0, row_cal_done, busy);
            end
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL stall_run0: cnt=%0d busy=%b expected 0 1", cnt, busy); end
        tick();
        checks++;
        if (cnt !== 4'd1) begin errors++; $display("FAIL stall_run1: cnt=%0d expected 1", cnt); end
        wait_cal(20, n, f);
        checks++;
        if (n !== 2 || f !== 1) begin errors++; $display("FAIL stall_cal: cycles=%0d fins=%0d expected 2 1", n, f); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL stall_done: done=%b expected 1", done); end
        tick();
    endtask

    task automatic test_ignored_start();
        int n, f;
        en = 1'b1; row_val_num = 4'd5;
        request(1'b0, 8'd1);
        cfg_start = 1'b1; cfg_mode = 1'b1; cfg_rows = 8'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || mode !== 1'b0 || cnt !== 4'(i)) begin
                errors++; $display("FAIL busy_start%0d: start=%b mode=%b cnt=%0d expected 0 0 %0d", i, start, mode, cnt, i);
            end
        end
        cfg_start = 1'b0;
        wait_cal(20, n, f);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL busy_cal: cycles=%0d expected 2", n); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL busy_done: done=%b expected 1", done); end
        tick();
        request(1'b1, 8'd0);
        checks++;
        if (done !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rows0_done: done=%b start=%b busy=%b expected 1 0 0", done, start, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rows0_idle: done=%b start=%b busy=%b expected 0 0 0", done, start, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, f;
        logic [6:0] outs;
        en = 1'b1; row_val_num = 4'd4;
        request(1'b1, 8'd2);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (cnt !== 4'd1 || mode !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre: cnt=%0d mode=%b busy=%b expected 1 1 1", cnt, mode, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        outs = {start, mode, row_finish_done_0, row_cal_done, row_finish_done_1, busy, done};
        checks++;
        if (outs !== 7'b0 || cnt !== 4'd0) begin errors++; $display("FAIL mid_reset: outs=%b cnt=%0d expected 0000000 0", outs, cnt); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mid_no_done: done=%b expected 0", done); end
        reset = 1'b0;
        row_val_num = 4'd2;
        request(1'b0, 8'd1);
        checks++;
        if (start !== 1'b1 || mode !== 1'b0) begin errors++; $display("FAIL restart: start=%b mode=%b expected 1 0", start, mode); end
        wait_cal(20, n, f);
        checks++;
        if (n !== 2 || f !== 1) begin errors++; $display("FAIL restart_cal: cycles=%0d fins=%0d expected 2 1", n, f); end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL restart_done: done=%b expected 1", done); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode0_rows();
        test_mode1_passes();
        test_zero_row();
        test_load_stall();
        test_ignored_start();
        test_reset_mid_run();
        checks++;
        if (row_finish_done_1 !== 1'b0) begin errors++; $display("FAIL reserved_bank: got %b expected 0", row_finish_done_1); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
